// File: rtl/pipewb.sv
// Write-back stage: MEM/WB pipeline register, load-response wait, load-data
// extension and write-back mux driving the register-file write port.
module pipewb (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_RegWrite,
  input  logic        mem_Memread,
  input  logic [4:0]  mem_rd,
  input  logic [1:0]  mem_WDSel,
  input  logic [3:0]  mem_ls,
  input  logic [31:0] mem_aluout,
  input  logic [31:0] mem_pc,
  input  logic [31:0] dm_rdata,
  input  logic        dm_rvalid,
  output logic        RegWrite,
  output logic [4:0]  rd,
  output logic [31:0] WD,
  output logic        wb_stall,
  output logic [1:0]  state_dbg
);

  // Handshake: dm_rvalid is a one-cycle valid strobe with no ready; it is
  // consumed only while a load is outstanding. wb_stall acts as the inverse
  // of ready toward MEM: a MEM instruction is taken on any edge with wb_stall=0.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LWAIT  = 2'd1,
    LWRITE = 2'd2
  } state_t;

  localparam logic [3:0] LS_LH  = 4'd1;
  localparam logic [3:0] LS_LHU = 4'd2;
  localparam logic [3:0] LS_LB  = 4'd3;
  localparam logic [3:0] LS_LBU = 4'd4;

  state_t      state, state_next;
  logic        capture;

  logic        wb_valid;
  logic        wb_regwrite;
  logic        wb_memread;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_wdsel;
  logic [3:0]  wb_ls;
  logic [31:0] wb_aluout;
  logic [31:0] wb_pc;
  logic [31:0] ldata;

  logic [15:0] half;
  logic [7:0]  byte_sel;
  logic [31:0] load_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_memread  <= 1'b0;
      wb_rd       <= 5'd0;
      wb_wdsel    <= 2'd0;
      wb_ls       <= 4'd0;
      wb_aluout   <= 32'd0;
      wb_pc       <= 32'd0;
      ldata       <= 32'd0;
    end else begin
      state <= state_next;
      if (capture) begin
        wb_valid    <= mem_valid;
        wb_regwrite <= mem_RegWrite;
        wb_memread  <= mem_Memread;
        wb_rd       <= mem_rd;
        wb_wdsel    <= mem_WDSel;
        wb_ls       <= mem_ls;
        wb_aluout   <= mem_aluout;
        wb_pc       <= mem_pc;
      end
      if (state == LWAIT && dm_rvalid) begin
        ldata <= dm_rdata;
      end
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE, LWRITE: begin
        capture    = 1'b1;
        state_next = (mem_valid && mem_Memread) ? LWAIT : IDLE;
      end
      LWAIT: begin
        if (dm_rvalid) state_next = LWRITE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Halfword picks by address bit 1 only; misaligned halfwords use the containing one.
  always_comb begin
    half     = wb_aluout[1] ? ldata[31:16] : ldata[15:0];
    byte_sel = 8'd0;
    case (wb_aluout[1:0])
      2'd0: byte_sel = ldata[7:0];
      2'd1: byte_sel = ldata[15:8];
      2'd2: byte_sel = ldata[23:16];
      2'd3: byte_sel = ldata[31:24];
      default: byte_sel = 8'd0;
    endcase
    case (wb_ls)
      LS_LH:   load_val = {{16{half[15]}}, half};
      LS_LHU:  load_val = {16'd0, half};
      LS_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      LS_LBU:  load_val = {24'd0, byte_sel};
      default: load_val = ldata;
    endcase
  end

  always_comb begin
    WD = 32'd0;
    case (wb_wdsel)
      2'b00:   WD = wb_aluout;
      2'b01:   WD = load_val;
      2'b10:   WD = wb_pc + 32'd4;
      default: WD = 32'd0;
    endcase
  end

  assign wb_stall  = (state == LWAIT);
  assign RegWrite  = wb_valid && wb_regwrite && (wb_rd != 5'd0) && (state != LWAIT);
  assign rd        = wb_rd;
  assign state_dbg = state;

  // Memread is carried with the instruction but the FSM already tracks load progress.
  logic unused_ok;
  assign unused_ok = wb_memread;

endmodule

// File: tb/tb_pipewb.sv
// Randomised and directed bench for pipewb against a behavioural model of the
// write-back stage (pending instruction, outstanding-load flag, load data).
module tb_pipewb;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_RegWrite, mem_Memread;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_WDSel;
  logic [3:0]  mem_ls;
  logic [31:0] mem_aluout, mem_pc, dm_rdata;
  logic        dm_rvalid;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] WD;
  logic        wb_stall;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fails  = 0;
  int stall_cnt;

  // reference model state
  bit          m_valid, m_rw, m_wait;
  logic [4:0]  m_rd;
  logic [1:0]  m_sel;
  logic [3:0]  m_ls;
  logic [31:0] m_alu, m_pc, m_ldata;

  pipewb dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite), .mem_Memread(mem_Memread),
    .mem_rd(mem_rd), .mem_WDSel(mem_WDSel), .mem_ls(mem_ls),
    .mem_aluout(mem_aluout), .mem_pc(mem_pc),
    .dm_rdata(dm_rdata), .dm_rvalid(dm_rvalid),
    .RegWrite(RegWrite), .rd(rd), .WD(WD), .wb_stall(wb_stall),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [3:0] ls, input logic [31:0] addr,
                                             input logic [31:0] w);
    longint unsigned b, h;
    b = (longint'(w) >> (8 * (addr % 4))) % 256;
    h = (longint'(w) >> (16 * ((addr % 4) / 2))) % 65536;
    case (ls)
      4'd1:    return (h >= 32768) ? 32'(h + 64'hFFFF0000) : 32'(h);
      4'd2:    return 32'(h);
      4'd3:    return (b >= 128) ? 32'(b + 64'hFFFFFF00) : 32'(b);
      4'd4:    return 32'(b);
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_wd();
    case (m_sel)
      2'b00:   return m_alu;
      2'b01:   return model_load(m_ls, m_alu, m_ldata);
      2'b10:   return 32'(longint'(m_pc) + 4);
      default: return 32'd0;
    endcase
  endfunction

  // One rising edge: advance the model with the inputs present at the edge,
  // then compare every output against it.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_rw = 0; m_wait = 0; m_rd = 0; m_sel = 0; m_ls = 0;
      m_alu = 0; m_pc = 0; m_ldata = 0;
    end else if (m_wait) begin
      if (dm_rvalid) begin
        m_ldata = dm_rdata;
        m_wait  = 0;
      end
    end else begin
      m_valid = mem_valid; m_rw = mem_RegWrite; m_rd = mem_rd;
      m_sel = mem_WDSel; m_ls = mem_ls; m_alu = mem_aluout; m_pc = mem_pc;
      m_wait = mem_valid && mem_Memread;
    end
    #1;
    check("regwrite", 32'(RegWrite), 32'(m_valid && m_rw && m_rd != 0 && !m_wait));
    check("rd", 32'(rd), 32'(m_rd));
    check("wd", WD, model_wd());
    check("stall", 32'(wb_stall), 32'(m_wait));
    if (wb_stall) stall_cnt++;
  endtask

  task automatic drive_random();
    mem_valid    = 1'($urandom_range(0, 1));
    mem_RegWrite = 1'($urandom_range(0, 1));
    mem_Memread  = 1'($urandom_range(0, 1));
    mem_rd       = 5'($urandom_range(0, 31));
    mem_WDSel    = 2'($urandom_range(0, 3));
    mem_ls       = 4'($urandom_range(0, 15));
    mem_aluout   = $urandom;
    mem_pc       = $urandom;
    dm_rdata     = $urandom;
    dm_rvalid    = ($urandom_range(0, 2) == 0);
  endtask

  task automatic drive_bubble();
    mem_valid = 0; mem_RegWrite = 0; mem_Memread = 0; mem_rd = 0;
    mem_WDSel = 0; mem_ls = 0; mem_aluout = 0; mem_pc = 0; dm_rvalid = 0;
  endtask

  task automatic drive_inst(input bit ld, input logic [4:0] r, input logic [1:0] sel,
                            input logic [3:0] ls, input logic [31:0] alu, input logic [31:0] pc);
    mem_valid = 1; mem_RegWrite = 1; mem_Memread = ld; mem_rd = r;
    mem_WDSel = sel; mem_ls = ls; mem_aluout = alu; mem_pc = pc; dm_rvalid = 0;
  endtask

  // Capture a load, return data after `delay` wait cycles, then check the write.
  task automatic run_load(input logic [3:0] ls, input logic [31:0] addr, input logic [31:0] data,
                          input int delay, input logic [31:0] exp_wd, input int exp_stall);
    @(negedge clk);
    drive_inst(1, 5'd7, 2'b01, ls, addr, 32'h100);
    stall_cnt = 0;
    tick();
    for (int i = 0; i <= delay; i++) begin
      @(negedge clk);
      dm_rvalid = (i == delay);
      dm_rdata  = (i == delay) ? data : $urandom;
      tick();
    end
    check("load_stall_cycles", 32'(stall_cnt), 32'(exp_stall));
    check("load_we", 32'(RegWrite), 32'd1);
    check("load_wd", WD, exp_wd);
    @(negedge clk);
    drive_bubble();
    tick();
  endtask

  initial begin
    rst = 1;
    drive_random();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_random();
      tick();
    end
    check("reset_we", 32'(RegWrite), 32'd0);
    check("reset_rd", 32'(rd), 32'd0);
    check("reset_wd", WD, 32'd0);
    check("reset_stall", 32'(wb_stall), 32'd0);
    @(negedge clk);
    rst = 0;
    drive_bubble();
    tick();

    // ALU write, then same with x0
    @(negedge clk);
    drive_inst(0, 5'd5, 2'b00, 4'd0, 32'h12345678, 32'h0);
    tick();
    check("alu_we", 32'(RegWrite), 32'd1);
    check("alu_rd", 32'(rd), 32'd5);
    check("alu_wd", WD, 32'h12345678);
    check("alu_stall", 32'(wb_stall), 32'd0);
    @(negedge clk);
    drive_inst(0, 5'd0, 2'b00, 4'd0, 32'h12345678, 32'h0);
    tick();
    check("x0_we", 32'(RegWrite), 32'd0);

    // JAL link with PC wrap
    @(negedge clk);
    drive_inst(0, 5'd1, 2'b10, 4'd0, 32'h0, 32'hFFFFFFFC);
    tick();
    check("jal_wd", WD, 32'h00000000);
    check("jal_we", 32'(RegWrite), 32'd1);
    @(negedge clk);
    drive_bubble();
    tick();
    check("bubble_we", 32'(RegWrite), 32'd0);

    run_load(4'd3, 32'h103, 32'h80FF7F01, 3, 32'hFFFFFF80, 4);
    run_load(4'd4, 32'h103, 32'h80FF7F01, 3, 32'h00000080, 4);
    run_load(4'd1, 32'h202, 32'h8001FFFF, 0, 32'hFFFF8001, 1);
    run_load(4'd2, 32'h200, 32'h8001FFFF, 0, 32'h0000FFFF, 1);
    run_load(4'd0, 32'h200, 32'h8001FFFF, 1, 32'h8001FFFF, 2);

    // Reset while waiting on a load, with a response in the reset cycle
    @(negedge clk);
    drive_inst(1, 5'd9, 2'b01, 4'd0, 32'h40, 32'h0);
    tick();
    @(negedge clk);
    rst = 1; dm_rvalid = 1; dm_rdata = 32'hDEADBEEF;
    tick();
    check("rstwait_we", 32'(RegWrite), 32'd0);
    check("rstwait_stall", 32'(wb_stall), 32'd0);
    check("rstwait_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    rst = 0;
    drive_bubble();
    tick();
    check("rstwait_after_we", 32'(RegWrite), 32'd0);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      drive_random();
      rst = ($urandom_range(0, 60) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pipewb.md
# pipewb

Write-back stage of the five-stage pipelined CPU. It holds the MEM/WB pipeline register, waits on the data-memory read handshake for loads, and sign- or zero-extends the returned load data. It selects the write-back value and drives the `RegWrite`/`rd`/`WD` triple consumed by the decode stage's register-file write port. It also back-pressures the pipeline while a load response is outstanding.

## Interface
Parameters: none.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `mem_valid`  in  1  MEM stage presents a valid instruction.
- `mem_RegWrite`  in  1  instruction writes rd.
- `mem_Memread`  in  1  instruction is a load.
- `mem_rd`  in  5  destination register.
- `mem_WDSel`  in  2  write-data select: 00 ALU, 01 load data, 10 PC+4, 11 zero.
- `mem_ls`  in  4  load type: 0000 lw, 0001 lh, 0010 lhu, 0011 lb, 0100 lbu; any other code is treated as lw.
- `mem_aluout`  in  32  ALU result; for loads this is the byte address.
- `mem_pc`  in  32  PC of the instruction.
- `dm_rdata`  in  32  data-memory read word, aligned to a word address.
- `dm_rvalid`  in  1  `dm_rdata` is valid this cycle.
- `RegWrite`  out  1  register-file write enable.
- `rd`  out  5  register-file write address.
- `WD`  out  32  register-file write data.
- `wb_stall`  out  1  MEM and earlier stages must hold their state this cycle.

## Operation
- Stage register fields: valid, RegWrite, Memread, rd, WDSel, ls, aluout, pc, plus a 32-bit load-data register ldata.
- Capture rule: on a rising edge with `wb_stall`=0, every stage-register field loads from the `mem_*` inputs. A bubble is captured when `mem_valid`=0.
- States:
  - IDLE: register empty or holding a non-load.
  - LWAIT: load captured, response outstanding.
  - LWRITE: load data held in ldata.
- Transitions:
  - IDLE or LWRITE with capture: go to LWAIT if `mem_valid` and `mem_Memread` are both 1; otherwise go to IDLE.
  - LWAIT with `dm_rvalid`=1: ldata ← `dm_rdata`, go to LWRITE. LWAIT with `dm_rvalid`=0: stay.
  - `dm_rvalid` is ignored in IDLE and LWRITE.
- `wb_stall` = (state == LWAIT). It is combinational from state only and has no path from `dm_rvalid`.
- `RegWrite` = valid & RegWrite & (rd != 0) & (state != LWAIT). Writes to x0 are always suppressed.
- `rd` = stage rd.
- WD selection:
  - WDSel 00: WD = aluout.
  - WDSel 10: WD = pc + 4, modulo 2^32.
  - WDSel 11: WD = 0.
  - WDSel 01: WD = extracted ldata.
- Load extraction, with a = aluout[1:0]:
  - lw: the full word; a is ignored.
  - lh / lhu: halfword ldata[16·a[1] +: 16], sign- or zero-extended. a[0] is ignored, so misaligned accesses use the containing halfword.
  - lb / lbu: byte ldata[8·a +: 8], sign- or zero-extended.
- WDSel=01 on a non-load still uses ldata; this case is a don't-care for software but must be deterministic.

## Timing
- Reset (synchronous): state IDLE, all stage fields and ldata set to 0. Therefore `RegWrite`=0, `rd`=0, `WD`=0, `wb_stall`=0 in the cycle after the reset edge.
- `rst` asserted mid-load (in LWAIT or LWRITE) abandons the load. A `dm_rvalid` in the reset cycle is ignored.
- Non-load latency: captured at edge E; `RegWrite`/`WD` are valid for exactly one cycle, the cycle following E.
- Load latency: captured at edge E; the write occurs one cycle after the `dm_rvalid` cycle.
  - Best case: `dm_rvalid` is high in the cycle after E, giving the write at E+2.
  - `wb_stall` is high from E through the `dm_rvalid` cycle.
- Back-to-back loads: the next load is captured at the end of the LWRITE cycle, so there are no idle cycles between write-backs beyond the memory wait.
- `RegWrite`, `rd` and `WD` are stable for the whole write cycle; the register file samples them at the following edge.

## Test plan
- Reset: hold `rst` for 2 cycles with random inputs → `RegWrite`=0, `rd`=0, `WD`=0, `wb_stall`=0.
- ALU write: present rd=5, WDSel=00, aluout=0x12345678 → one cycle later `RegWrite`=1, `rd`=5, `WD`=0x12345678, `wb_stall`=0. The same stimulus with rd=0 gives `RegWrite`=0.
- JAL link: present WDSel=10, pc=0xFFFFFFFC, rd=1 → `WD`=0x00000000 (wrap), `RegWrite`=1.
- lb at aluout=0x103 with `dm_rvalid` delayed 3 cycles and rdata=0x80FF7F01:
  - `wb_stall` is high for 4 cycles.
  - The write follows with `WD`=0xFFFFFF80.
  - Repeating with lbu gives `WD`=0x00000080.
- lh at aluout=0x202 with rdata=0x8001FFFF → `WD`=0xFFFF8001. lhu at 0x200 with the same data → `WD`=0x0000FFFF. lw → `WD`=0x8001FFFF.
- Reset in LWAIT: assert `rst` 1 cycle after capturing a load, with `dm_rvalid` pulsed in the same cycle → no write occurs, state is IDLE, `wb_stall`=0 afterward.
